cpu_reset_sequencer: RTL and testbench
======================================

CPU_RESET_SEQUENCER -- requirements
Module: cpu_reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles both reset outputs stay asserted after a trigger; legal range 1..255.
REQ-002 Parameter STAGGER_CYCLES, default 8: cycles between peripheral release and CPU release; legal range 1..255.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000: stability window for ext_reset_req; used only with the debounce feature.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high power-on reset.
REQ-006 wdt_resetrequest  input  1  watchdog reset request, high 2 cycles per timeout.
REQ-007 ext_reset_req  input  1  asynchronous pushbutton request, active-high.
REQ-008 address  input  2  Avalon slave word address.
REQ-009 chipselect  input  1  Avalon slave select.
REQ-010 write_n  input  1  Avalon write strobe, active-low.
REQ-011 writedata  input  16  Avalon write data.
REQ-012 readdata  output  16  Avalon read data, registered.
REQ-013 periph_reset_out  output  1  active-high reset to peripherals, including the watchdog.
REQ-014 cpu_reset_out  output  1  active-high reset to the CPU.

Function
REQ-015 FSM states: ASSERT_ALL, RELEASE_PERIPH, RUN; one down-counter (8 bits) shared by ASSERT_ALL and RELEASE_PERIPH.
REQ-016 ASSERT_ALL: both outputs 1; counter loaded with HOLD_CYCLES-1 on entry; at count 0 -> RELEASE_PERIPH.
REQ-017 RELEASE_PERIPH: periph_reset_out 0, cpu_reset_out 1; counter loaded with STAGGER_CYCLES-1 on entry; at count 0 -> RUN.
REQ-018 RUN: both outputs 0; any trigger -> ASSERT_ALL on the next edge.
REQ-019 Outputs are registered decodes of the state; no combinational path from any input to an output.
REQ-020 Watchdog trigger: rising edge of wdt_resetrequest (registered-previous compare); the 2-cycle pulse yields exactly one trigger.
REQ-021 External trigger: ext_reset_req passes a 2-flop synchronizer; its synchronized rising edge is the trigger.
REQ-022 Software trigger: write to address 1 with writedata[7:0] = 0xA5; any other value has no effect.
REQ-023 Triggers arriving outside RUN are ignored: no restart, no cause update, no count update.
REQ-024 Simultaneous triggers in RUN start one sequence and set every matching cause bit.
REQ-025 Cause register, 4 bits, sticky: [0] power-on, [1] watchdog, [2] external, [3] software; set on the trigger edge; survives sequencer-generated resets.
REQ-026 Address 0 read: {12'b0, cause}; write: bits set in writedata[3:0] clear the matching cause bits (write-1-to-clear); clear and set on the same edge -> set wins.
REQ-027 Address 1 read: {14'b0, cpu_reset_out, periph_reset_out}.
REQ-028 Address 2 read: {8'b0, wdt_count}; wdt_count increments per accepted watchdog trigger, saturates at 255; any write to address 2 clears it.
REQ-029 Address 3 reads 0; writes ignored.
REQ-030 readdata is valid one cycle after the chipselect cycle, is updated every cycle from the address mux, and is independent of write_n.

Reset
REQ-031 While reset is high: state ASSERT_ALL, counter HOLD_CYCLES-1, cause = 4'b0001, wdt_count 0, readdata 0, periph_reset_out 1, cpu_reset_out 1, edge/synchronizer flops 0.
REQ-032 After reset falls, the sequence runs without further stimulus: peripheral release after HOLD_CYCLES cycles, CPU release STAGGER_CYCLES cycles later.
REQ-033 reset asserted mid-sequence or in RUN restarts the sequence from ASSERT_ALL on the same edge.

Configuration
REQ-034 Macro CPU_RESET_SEQ_DEBOUNCE_EN defined: the synchronized ext_reset_req must stay high for DEBOUNCE_CYCLES consecutive cycles before producing one trigger; any low sample restarts the window; no new trigger until the input has been low.
REQ-035 Macro undefined: no debounce logic; every synchronized rising edge is a trigger, per REQ-021.

Verification
REQ-036 Power-on: reset high 3 cycles, then low -> periph_reset_out falls 16 cycles later, cpu_reset_out 8 cycles after that; address 0 reads 0x0001.
REQ-037 In RUN, drive wdt_resetrequest high 2 cycles -> exactly one sequence; cause bit1 set; address 2 reads 1; a second pulse during the sequence -> count stays 1.
REQ-038 In RUN, write 0x00A5 to address 1 -> sequence starts next edge and cause reads 0x0009; write 0x005A -> no effect.
REQ-039 Write 0x000F to address 0 on the same cycle as a watchdog trigger edge -> cause reads 0x0002.
REQ-040 With the macro defined, ext_reset_req high 500 cycles, low, then high 1200 cycles -> one trigger, cause bit2 set; with the macro undefined, the first edge triggers.
REQ-041 Drive 256 watchdog triggers, each after the sequence completes -> address 2 reads 0x00FF.

Source files
------------

// File: rtl/cpu_reset_sequencer.sv
// cpu_reset_sequencer: staged peripheral/CPU reset release with cause log.
// Define CPU_RESET_SEQ_DEBOUNCE_EN to debounce ext_reset_req.
module cpu_reset_sequencer #(
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wdt_resetrequest,
    input  logic        ext_reset_req,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        periph_reset_out,
    output logic        cpu_reset_out
);

    localparam logic [1:0] ASSERT_ALL     = 2'd0;
    localparam logic [1:0] RELEASE_PERIPH = 2'd1;
    localparam logic [1:0] RUN            = 2'd2;

    localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] STAGGER_LOAD = 8'(STAGGER_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] count;
    logic [7:0] count_next;
    logic [3:0] cause;
    logic [3:0] cause_set;
    logic [3:0] cause_clr;
    logic [7:0] wdt_count;
    logic       wdt_prev;
    logic       ext_meta;
    logic       ext_sync;
    logic       wdt_trig;
    logic       ext_trig;
    logic       sw_trig;
    logic       in_run;
    logic       any_trig;
    logic       wr_cause;
    logic       wr_ctrl;
    logic       wr_wdt;
    logic       unused_writedata;

    assign unused_writedata = ^writedata[15:8];

    assign wr_cause = chipselect && !write_n && (address == 2'd0);
    assign wr_ctrl  = chipselect && !write_n && (address == 2'd1);
    assign wr_wdt   = chipselect && !write_n && (address == 2'd2);

    assign in_run   = (state == RUN);
    assign wdt_trig = wdt_resetrequest && !wdt_prev;
    assign sw_trig  = wr_ctrl && (writedata[7:0] == 8'hA5);
    assign any_trig = in_run && (wdt_trig || ext_trig || sw_trig);

    // Edge detect for the watchdog and 2-flop synchronizer for the button.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_prev <= 1'b0;
            ext_meta <= 1'b0;
            ext_sync <= 1'b0;
        end else begin
            wdt_prev <= wdt_resetrequest;
            ext_meta <= ext_reset_req;
            ext_sync <= ext_meta;
        end
    end

`ifdef CPU_RESET_SEQ_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [DBW-1:0] db_count;
    logic           db_fired;

    assign ext_trig = ext_sync && !db_fired && (db_count == DB_LAST);

    // Count consecutive high samples; fire once per high period.
    always_ff @(posedge clk) begin
        if (reset || !ext_sync) begin
            db_count <= '0;
            db_fired <= 1'b0;
        end else if (!db_fired) begin
            if (db_count == DB_LAST) begin
                db_fired <= 1'b1;
            end else begin
                db_count <= db_count + 1'b1;
            end
        end
    end
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;

    logic ext_prev;

    assign ext_trig = ext_sync && !ext_prev;

    // Previous synchronized level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_prev <= 1'b0;
        end else begin
            ext_prev <= ext_sync;
        end
    end
`endif

    // Next-state and shared down-counter logic for the release sequence.
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            ASSERT_ALL: begin
                if (count == 8'd0) begin
                    state_next = RELEASE_PERIPH;
                    count_next = STAGGER_LOAD;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            RELEASE_PERIPH: begin
                if (count == 8'd0) begin
                    state_next = RUN;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            RUN: begin
                if (any_trig) begin
                    state_next = ASSERT_ALL;
                    count_next = HOLD_LOAD;
                end
            end
            default: begin
                state_next = ASSERT_ALL;
                count_next = HOLD_LOAD;
            end
        endcase
    end

    // State register; outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ASSERT_ALL;
            count            <= HOLD_LOAD;
            periph_reset_out <= 1'b1;
            cpu_reset_out    <= 1'b1;
        end else begin
            state            <= state_next;
            count            <= count_next;
            periph_reset_out <= (state_next == ASSERT_ALL);
            cpu_reset_out    <= (state_next != RUN);
        end
    end

    assign cause_set = any_trig ? {sw_trig, ext_trig, wdt_trig, 1'b0} : 4'b0;
    assign cause_clr = wr_cause ? writedata[3:0] : 4'b0;

    // Sticky cause bits; a new cause beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause <= 4'b0001;
        end else begin
            cause <= (cause & ~cause_clr) | cause_set;
        end
    end

    // Saturating count of accepted watchdog resets.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_count <= 8'd0;
        end else if (any_trig && wdt_trig) begin
            if (wdt_count != 8'hFF) begin
                wdt_count <= wdt_count + 8'd1;
            end
        end else if (wr_wdt) begin
            wdt_count <= 8'd0;
        end
    end

    // Read mux registered every cycle, regardless of select or strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 16'h0000;
        end else begin
            case (address)
                2'd0:    readdata <= {12'b0, cause};
                2'd1:    readdata <= {14'b0, cpu_reset_out, periph_reset_out};
                2'd2:    readdata <= {8'b0, wdt_count};
                default: readdata <= 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// tb_cpu_reset_sequencer: randomized and directed checks of the
// reset sequencer against a cycle-count reference model.
module tb_cpu_reset_sequencer;

    localparam int HOLD = 16;
    localparam int STAG = 8;
    localparam int DB   = 1000;
    localparam int SEQ  = HOLD + STAG;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        wdt     = 1'b0;
    logic        ext     = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        cs      = 1'b0;
    logic        wn      = 1'b1;
    logic [15:0] wd      = 16'h0;
    logic [15:0] readdata;
    logic        periph;
    logic        cpu;

    int total = 0;
    int bad   = 0;

    // Reference model: m_k counts edges since the last sequence start.
    int          m_k     = 0;
    logic [3:0]  m_cause = 4'b0001;
    int          m_wcnt  = 0;
    logic        m_wprev = 1'b0;
    logic        m_s1    = 1'b0;
    logic        m_s2    = 1'b0;
    logic [15:0] m_rd    = 16'h0;
`ifdef CPU_RESET_SEQ_DEBOUNCE_EN
    int          m_dbh   = 0;
`else
    logic        m_eprev = 1'b0;
`endif

    cpu_reset_sequencer #(
        .HOLD_CYCLES(HOLD),
        .STAGGER_CYCLES(STAG),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wdt_resetrequest(wdt),
        .ext_reset_req(ext),
        .address(address),
        .chipselect(cs),
        .write_n(wn),
        .writedata(wd),
        .readdata(readdata),
        .periph_reset_out(periph),
        .cpu_reset_out(cpu)
    );

    always #5 clk = ~clk;

    function automatic logic exp_periph();
        return m_k < HOLD;
    endfunction

    function automatic logic exp_cpu();
        return m_k < SEQ;
    endfunction

    task automatic model_edge();
        logic [15:0] rd;
        logic [3:0]  clr;
        logic [3:0]  set;
        logic        run;
        logic        w;
        logic        e;
        logic        s;
        logic        wr2;
        case (address)
            2'd0:    rd = {12'b0, m_cause};
            2'd1:    rd = {14'b0, exp_cpu(), exp_periph()};
            2'd2:    rd = {8'b0, m_wcnt[7:0]};
            default: rd = 16'h0;
        endcase
        if (reset) begin
            m_rd    = 16'h0;
            m_k     = 0;
            m_cause = 4'b0001;
            m_wcnt  = 0;
            m_wprev = 1'b0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
`ifdef CPU_RESET_SEQ_DEBOUNCE_EN
            m_dbh   = 0;
`else
            m_eprev = 1'b0;
`endif
        end else begin
            m_rd = rd;
            run  = (m_k >= SEQ);
            w    = wdt && !m_wprev;
`ifdef CPU_RESET_SEQ_DEBOUNCE_EN
            m_dbh = m_s2 ? m_dbh + 1 : 0;
            e     = (m_dbh == DB);
`else
            e     = m_s2 && !m_eprev;
`endif
            s   = cs && !wn && address == 2'd1 && wd[7:0] == 8'hA5;
            wr2 = cs && !wn && address == 2'd2;
            clr = (cs && !wn && address == 2'd0) ? wd[3:0] : 4'b0;
            set = run ? {s, e, w, 1'b0} : 4'b0;
            m_cause = (m_cause & ~clr) | set;
            if (run && w) begin
                if (m_wcnt < 255) m_wcnt++;
            end else if (wr2) begin
                m_wcnt = 0;
            end
            if (run && (w || e || s)) m_k = 0;
            else if (m_k < SEQ) m_k++;
`ifndef CPU_RESET_SEQ_DEBOUNCE_EN
            m_eprev = m_s2;
`endif
            m_s2    = m_s1;
            m_s1    = ext;
            m_wprev = wdt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        cs  = 1'b0;
        wn  = 1'b1;
        wd  = 16'h0;
        wdt = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (cpu !== 1'b0) begin
            bad++;
            $display("FAIL wait_run cpu=%b want 0 after %0d cycles", cpu, n);
        end
    endtask

    task automatic test_reset();
        int fall_p;
        int fall_c;
        reset = 1'b1;
        idle();
        address = 2'd0;
        repeat (3) begin
            tick();
            total++;
            if (periph !== 1'b1 || cpu !== 1'b1 || readdata !== 16'h0) begin
                bad++;
                $display("FAIL reset_hold got p=%b c=%b rd=%h want 1 1 0000",
                         periph, cpu, readdata);
            end
        end
        reset  = 1'b0;
        fall_p = -1;
        fall_c = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (fall_p < 0 && periph === 1'b0) fall_p = i;
            if (fall_c < 0 && cpu === 1'b0) fall_c = i;
            total++;
            if (periph !== exp_periph() || cpu !== exp_cpu()) begin
                bad++;
                $display("FAIL power_on cyc=%0d got p=%b c=%b want p=%b c=%b",
                         i, periph, cpu, exp_periph(), exp_cpu());
            end
        end
        total++;
        if (fall_p != 16) begin
            bad++;
            $display("FAIL periph_release got=%0d want=16", fall_p);
        end
        total++;
        if (fall_c - fall_p != 8) begin
            bad++;
            $display("FAIL cpu_stagger got=%0d want=8", fall_c - fall_p);
        end
        tick();
        total++;
        if (readdata !== 16'h0001) begin
            bad++;
            $display("FAIL poweron_cause got=%h want=0001", readdata);
        end
    endtask

    task automatic test_watchdog();
        int   rises;
        logic last;
        idle();
        wait_run();
        address = 2'd2;
        last    = periph;
        rises   = 0;
        for (int i = 0; i < 40; i++) begin
            wdt = (i < 2) || (i == 5) || (i == 6);
            tick();
            if (periph === 1'b1 && last === 1'b0) rises++;
            last = periph;
            total++;
            if (periph !== exp_periph() || cpu !== exp_cpu() || readdata !== m_rd) begin
                bad++;
                $display("FAIL wdt_seq cyc=%0d got p=%b c=%b rd=%h want p=%b c=%b rd=%h",
                         i, periph, cpu, readdata, exp_periph(), exp_cpu(), m_rd);
            end
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL wdt_one_seq got=%0d want=1", rises);
        end
        tick();
        total++;
        if (readdata !== 16'h0001) begin
            bad++;
            $display("FAIL wdt_count got=%h want=0001", readdata);
        end
        address = 2'd0;
        tick();
        total++;
        if (readdata !== 16'h0003) begin
            bad++;
            $display("FAIL wdt_cause got=%h want=0003", readdata);
        end
    endtask

    task automatic test_software();
        cs = 1'b1; wn = 1'b0; address = 2'd0; wd = 16'h000E;
        tick();
        idle();
        wait_run();
        cs = 1'b1; wn = 1'b0; address = 2'd1; wd = 16'h00A5;
        tick();
        total++;
        if (periph !== 1'b1 || cpu !== 1'b1) begin
            bad++;
            $display("FAIL sw_start got p=%b c=%b want 1 1", periph, cpu);
        end
        wn = 1'b1;
        tick();
        total++;
        if (readdata !== 16'h0003) begin
            bad++;
            $display("FAIL status_read got=%h want=0003", readdata);
        end
        address = 2'd0;
        tick();
        total++;
        if (readdata !== 16'h0009) begin
            bad++;
            $display("FAIL sw_cause got=%h want=0009", readdata);
        end
        idle();
        wait_run();
        cs = 1'b1; wn = 1'b0; address = 2'd1; wd = 16'h005A;
        tick();
        address = 2'd3; wd = 16'hFFFF;
        tick();
        idle();
        tick();
        total++;
        if (readdata !== 16'h0000) begin
            bad++;
            $display("FAIL addr3_read got=%h want=0000", readdata);
        end
        address = 2'd0;
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if (periph !== 1'b0 || cpu !== 1'b0) begin
                bad++;
                $display("FAIL sw_ignored cyc=%0d got p=%b c=%b want 0 0", i, periph, cpu);
            end
        end
        total++;
        if (readdata !== 16'h0009) begin
            bad++;
            $display("FAIL sw_bad_key_cause got=%h want=0009", readdata);
        end
    endtask

    task automatic test_clear_collision();
        idle();
        wait_run();
        wdt = 1'b1; cs = 1'b1; wn = 1'b0; address = 2'd0; wd = 16'h000F;
        tick();
        cs = 1'b0; wn = 1'b1; wd = 16'h0;
        tick();
        wdt = 1'b0;
        tick();
        total++;
        if (readdata !== 16'h0002) begin
            bad++;
            $display("FAIL clr_set_cause got=%h want=0002", readdata);
        end
        address = 2'd2;
        tick();
        total++;
        if (readdata !== 16'h0002) begin
            bad++;
            $display("FAIL clr_set_count got=%h want=0002", readdata);
        end
    endtask

    task automatic test_external();
        idle();
        wait_run();
        cs = 1'b1; wn = 1'b0; address = 2'd0; wd = 16'h000F;
        tick();
        idle();
`ifdef CPU_RESET_SEQ_DEBOUNCE_EN
        begin
            int   rises;
            int   at;
            logic last;
            rises = 0;
            at    = -1;
            last  = periph;
            ext   = 1'b1;
            for (int i = 1; i <= 500; i++) begin
                tick();
                if (periph === 1'b1 && last === 1'b0) rises++;
                last = periph;
            end
            ext = 1'b0;
            repeat (10) tick();
            ext = 1'b1;
            for (int i = 1; i <= 1200; i++) begin
                tick();
                if (periph === 1'b1 && last === 1'b0) begin
                    rises++;
                    if (at < 0) at = i;
                end
                last = periph;
                total++;
                if (periph !== exp_periph() || cpu !== exp_cpu()) begin
                    bad++;
                    $display("FAIL ext_db cyc=%0d got p=%b c=%b want p=%b c=%b",
                             i, periph, cpu, exp_periph(), exp_cpu());
                end
            end
            total++;
            if (rises != 1) begin
                bad++;
                $display("FAIL ext_db_count got=%0d want=1", rises);
            end
            total++;
            if (at != 1002) begin
                bad++;
                $display("FAIL ext_db_latency got=%0d want=1002", at);
            end
        end
`else
        begin
            int lat;
            lat = -1;
            ext = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (lat < 0 && periph === 1'b1) lat = i;
            end
            total++;
            if (lat != 3) begin
                bad++;
                $display("FAIL ext_latency got=%0d want=3", lat);
            end
            wait_run();
            for (int i = 0; i < 20; i++) begin
                tick();
                total++;
                if (periph !== 1'b0) begin
                    bad++;
                    $display("FAIL ext_level_retrig cyc=%0d got=%b want=0", i, periph);
                end
            end
        end
`endif
        tick();
        total++;
        if (readdata !== 16'h0004) begin
            bad++;
            $display("FAIL ext_cause got=%h want=0004", readdata);
        end
        ext = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_saturate();
        idle();
        wait_run();
        cs = 1'b1; wn = 1'b0; address = 2'd2; wd = 16'h0;
        tick();
        idle();
        for (int n = 1; n <= 256; n++) begin
            wait_run();
            wdt = 1'b1;
            tick();
            tick();
            wdt = 1'b0;
            tick();
            if (n == 1 || n == 255 || n == 256) begin
                tick();
                total++;
                if (readdata !== 16'((n > 255) ? 255 : n) || readdata !== m_rd) begin
                    bad++;
                    $display("FAIL wdt_saturate n=%0d got=%h want=%h", n, readdata,
                             16'((n > 255) ? 255 : n));
                end
            end
        end
    endtask

    task automatic test_random();
        int wleft;
        wleft = 0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            if (wleft > 0) begin
                wdt = 1'b1;
                wleft--;
            end else if ($urandom_range(0, 29) == 0) begin
                wdt   = 1'b1;
                wleft = 1;
            end else begin
                wdt = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) ext = ~ext;
            cs      = 1'($urandom_range(0, 1));
            wn      = 1'($urandom_range(0, 1));
            address = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       wd = 16'h00A5;
                1:       wd = 16'($urandom_range(0, 15));
                default: wd = 16'($urandom);
            endcase
            if (wdt && !m_wprev && cs && !wn && address == 2'd2) wn = 1'b1;
            tick();
            total++;
            if (periph !== exp_periph() || cpu !== exp_cpu() || readdata !== m_rd) begin
                bad++;
                $display("FAIL random cyc=%0d got p=%b c=%b rd=%h want p=%b c=%b rd=%h",
                         i, periph, cpu, readdata, exp_periph(), exp_cpu(), m_rd);
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_watchdog();
        test_software();
        test_clear_collision();
        test_external();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
